// File: rtl/hpdcache_pkg.sv
// Shared HPDcache core request/response types and widths.
// Consumed by the request arbiter and its round-robin sub-module.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_REQ_SRC_ID_WIDTH   = 3;
    localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 4;
    localparam int unsigned HPDCACHE_REQ_SID_MAX        = 2 ** HPDCACHE_REQ_SRC_ID_WIDTH;

    typedef logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0]   hpdcache_req_sid_t;
    typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;

    typedef enum logic [1:0] {
        HPDCACHE_REQ_LOAD  = 2'd0,
        HPDCACHE_REQ_STORE = 2'd1,
        HPDCACHE_REQ_AMO   = 2'd2,
        HPDCACHE_REQ_CMO   = 2'd3
    } hpdcache_req_op_t;

    typedef struct packed {
        logic [31:0]       addr;
        hpdcache_req_op_t  op;
        logic [31:0]       wdata;
        logic [3:0]        be;
        hpdcache_req_tid_t tid;
        hpdcache_req_sid_t sid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        logic              error;
        hpdcache_req_tid_t tid;
        hpdcache_req_sid_t sid;
    } hpdcache_rsp_t;

endpackage

// File: rtl/hpdcache_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping modulo N.
// Zero latency; gnt is forced to zero when en is low (caller's backpressure).
module hpdcache_rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic        w_found;
    int unsigned w_j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single wrap subtraction is enough
            w_j = 32'(ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && req[w_j[IW-1:0]]) begin
                w_found = 1'b1;
                gnt_idx = w_j[IW-1:0];
            end
        end
        gnt[gnt_idx] = en & w_found;
    end

endmodule

// File: rtl/hpdcache_core_req_arbiter.sv
// Round-robin merge of NREQUESTERS request streams into one registered dcache request; sid-based response fan-out.
// Request: grant in cycle t, visible on dcache_req_o in t+1; a new grant needs an empty or draining output stage. Responses: zero latency, no backpressure.
module hpdcache_core_req_arbiter
    import hpdcache_pkg::*;
#(
    parameter int unsigned NREQUESTERS = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQUESTERS-1:0] core_req_valid_i,
    output logic [NREQUESTERS-1:0] core_req_ready_o,
    input  hpdcache_req_t          core_req_i [NREQUESTERS],
    output logic [NREQUESTERS-1:0] core_rsp_valid_o,
    output hpdcache_rsp_t          core_rsp_o [NREQUESTERS],
    output logic                   dcache_req_valid_o,
    input  logic                   dcache_req_ready_i,
    output hpdcache_req_t          dcache_req_o,
    input  logic                   dcache_rsp_valid_i,
    input  hpdcache_rsp_t          dcache_rsp_i,
    output logic                   rsp_sid_err_o
);

    localparam int unsigned IW   = (NREQUESTERS > 1) ? $clog2(NREQUESTERS) : 1;
    localparam int unsigned SIDW = HPDCACHE_REQ_SRC_ID_WIDTH;
    localparam logic [SIDW:0] NREQ_W = (SIDW + 1)'(NREQUESTERS);

    logic          r_out_vld;
    hpdcache_req_t r_out;
    logic [IW-1:0] r_ptr;
    logic          r_sid_err;

    logic                   w_can_load;
    logic [NREQUESTERS-1:0] w_gnt;
    logic [IW-1:0]          w_gnt_idx;
    logic                   w_grant;
    logic [IW-1:0]          w_ptr_nxt;
    hpdcache_req_t          w_sel;
    logic                   w_sid_illegal;

    assign w_can_load = ~r_out_vld | dcache_req_ready_i;

    hpdcache_rr_arbiter #(
        .N (NREQUESTERS)
    ) u_rr_arb (
        .req     (core_req_valid_i),
        .ptr     (r_ptr),
        .en      (w_can_load & ~rst_i),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign core_req_ready_o = w_gnt;
    assign w_grant          = |w_gnt;
    assign w_ptr_nxt        = (w_gnt_idx == IW'(NREQUESTERS - 1)) ? '0 : w_gnt_idx + 1'b1;

    // The winner's port index replaces the requester-supplied sid so responses route home
    always_comb begin
        w_sel     = core_req_i[w_gnt_idx];
        w_sel.sid = hpdcache_req_sid_t'(w_gnt_idx);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
            r_ptr     <= '0;
            r_sid_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_out     <= w_sel;
                r_out_vld <= 1'b1;
                r_ptr     <= w_ptr_nxt;
            end else if (dcache_req_ready_i) begin
                r_out_vld <= 1'b0;
            end
            if (w_sid_illegal) begin
                r_sid_err <= 1'b1;
            end
        end
    end

    assign dcache_req_valid_o = r_out_vld;
    assign dcache_req_o       = r_out;
    assign rsp_sid_err_o      = r_sid_err;

    assign w_sid_illegal = dcache_rsp_valid_i & ({1'b0, dcache_rsp_i.sid} >= NREQ_W);

    for (genvar i = 0; i < NREQUESTERS; i++) begin : g_rsp
        assign core_rsp_valid_o[i] = dcache_rsp_valid_i & (dcache_rsp_i.sid == hpdcache_req_sid_t'(i));
        assign core_rsp_o[i]       = dcache_rsp_i;
    end

    a_req_rdy_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(core_req_ready_o));
    a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (dcache_req_valid_o && !dcache_req_ready_i) |=> $stable(dcache_req_o));
    a_rsp_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(core_rsp_valid_o));

endmodule
